apb_gpio_bank: RTL and testbench
================================

Name: apb_gpio_bank

Overview:
- Parametrised APB3 slave GPIO bank in the fabric, hung off the MSS fabric APB master port (MSSPSEL/MSSPADDR group).
- Replaces the single fixed MSS GPIO pin with NUM_IO fabric pins, each with:
  - per-pin direction control;
  - synchronised, debounced input;
  - configurable edge interrupt, combined into one level IRQ toward MSS FABINT.

Parameters:
- NUM_IO, 8, number of GPIO channels (1..32).
- DB_W, 16, debounce counter/register width (1..32).
- DB_RESET, 1000, reset value of the DEBOUNCE register in FAB_CLK cycles.

Ports:
- FAB_CLK  in  1  sole clock.
- M2F_RESET_N  in  1  reset; synchronous, active-low.
- PSEL  in  1  APB select.
- PENABLE  in  1  APB enable.
- PWRITE  in  1  APB write.
- PADDR  in  8  byte address; bits [1:0] ignored.
- PWDATA  in  32  write data.
- PRDATA  out  32  read data.
- PREADY  out  1  always 1 (zero wait states).
- PSLVERR  out  1  error on unmapped access.
- GPIO_IN  in  NUM_IO  asynchronous pin inputs.
- GPIO_OUT  out  NUM_IO  output values.
- GPIO_OE  out  NUM_IO  output enables, 1 = drive.
- IRQ  out  1  level interrupt, registered.

Behaviour:
- Clock and reset: one clock, FAB_CLK. Reset M2F_RESET_N is synchronous and active-low. While it is low at a rising edge, every register returns to its reset value at that edge, including sync flops, debounce counters and in-flight edge state.
- Reset values: all outputs and registers 0, except DEBOUNCE = DB_RESET and PREADY = 1.
- APB access:
  - Access phase = PSEL & PENABLE.
  - A write commits on the access-phase edge.
  - PRDATA is a combinational mux of the registers during the access phase, else 0.
  - Bits at and above NUM_IO (DB_W for DEBOUNCE) read 0 and ignore writes.
- Register map (byte offset):
  - 0x00 DATA_IN (RO): debounced inputs.
  - 0x04 DATA_OUT (RW).
  - 0x08 DIR (RW).
  - 0x0C IRQ_EN (RW).
  - 0x10 IRQ_POL (RW): 0 = rising, 1 = falling.
  - 0x14 IRQ_STAT (W1C).
  - 0x18 DEBOUNCE (RW).
- Unmapped offset: PSLVERR = 1 during the access phase, PRDATA = 0, no state change. A write to DATA_IN is also an error.
- Outputs: GPIO_OUT = DATA_OUT register and GPIO_OE = DIR register (register outputs, 1-cycle after the write edge). Output pins are still sampled into DATA_IN.
- Per-channel debounce:
  - Input path: 2-flop synchroniser s1→s2, then the debounce stage.
  - Each edge, if s2 != stable: when cnt == DEBOUNCE, set stable <= s2 and cnt <= 0; otherwise cnt <= cnt+1.
  - If s2 == stable: cnt <= 0, so a glitch shorter than the window is discarded.
  - DATA_IN changes on the (DEBOUNCE+3)th edge, counting the first edge that samples the new pin value as edge 1. DEBOUNCE = 0 gives 3 edges.
  - A DEBOUNCE write mid-count takes effect in the next compare; a counter already above the new value completes by wrapping.
- Edge capture:
  - stable_d is stable delayed 1 cycle.
  - An event is (stable & ~stable_d) when IRQ_POL = 0, and (~stable & stable_d) when IRQ_POL = 1.
  - An event sets IRQ_STAT bit 1 cycle after the stable change.
  - A W1C write and a new event on the same bit in the same cycle leave the bit set (set wins).
  - Since stable_d resets to 0, a pin held high through reset produces a rising event after debounce. Software clears IRQ_STAT before enabling.
- IRQ <= |(IRQ_STAT & IRQ_EN), registered; 1-cycle latency from IRQ_STAT or IRQ_EN change.

Optional Feature:
- Macro GPIO_ATOMIC_EN.
- Defined:
  - 0x1C DATA_SET (WO): DATA_OUT |= PWDATA.
  - 0x20 DATA_CLR (WO): DATA_OUT &= ~PWDATA.
  - Both read 0.
- Undefined: 0x1C and 0x20 are unmapped (PSLVERR = 1).

Decomposition:
- Package gpio_pkg: register offset localparams, IRQ_POL encoding constants, helper function for the address-to-register-select decode.
- Sub-module gpio_debounce: one channel, containing synchroniser, counter, stable and stable_d. Instantiated NUM_IO times via generate; DEBOUNCE value fanned in.

Test Plan:
- Reset: hold M2F_RESET_N low 2 cycles → all outputs 0, PRDATA read of 0x18 returns DB_RESET (1000), IRQ = 0.
- Write DIR = 0x0F, DATA_OUT = 0xA5 → GPIO_OE = 0x0F, GPIO_OUT = 0xA5 the cycle after each write; readback matches; access to 0x24 gives PSLVERR = 1 with no state change.
- Debounce: DEBOUNCE = 4; GPIO_IN[0] rises → DATA_IN[0] = 1 on edge 7. A 3-cycle pulse on GPIO_IN[1] → DATA_IN[1] never changes.
- Interrupt: IRQ_EN = 0x01, IRQ_POL = 0, pin 0 rises → IRQ_STAT = 0x01, then IRQ = 1 one cycle later. W1C 0x01 coincident with a new event → bit stays 1. Plain W1C → IRQ drops the cycle after.
- Falling polarity: IRQ_POL[2] = 1; pin 2 rise → no status; pin 2 fall → IRQ_STAT[2] = 1.
- With GPIO_ATOMIC_EN: DATA_OUT = 0x0F, SET 0x30 → 0x3F, CLR 0x05 → 0x3A. Without the macro: write 0x1C → PSLVERR = 1.

Source files
------------

// File: rtl/gpio_pkg.sv
// Register map, IRQ polarity encoding and address decode for apb_gpio_bank.
// GPIO_ATOMIC_EN adds the DATA_SET / DATA_CLR aliases to the decode.
package gpio_pkg;

  localparam logic [7:0] OFF_DATA_IN  = 8'h00;
  localparam logic [7:0] OFF_DATA_OUT = 8'h04;
  localparam logic [7:0] OFF_DIR      = 8'h08;
  localparam logic [7:0] OFF_IRQ_EN   = 8'h0C;
  localparam logic [7:0] OFF_IRQ_POL  = 8'h10;
  localparam logic [7:0] OFF_IRQ_STAT = 8'h14;
  localparam logic [7:0] OFF_DEBOUNCE = 8'h18;
  localparam logic [7:0] OFF_DATA_SET = 8'h1C;
  localparam logic [7:0] OFF_DATA_CLR = 8'h20;

  localparam logic POL_RISE = 1'b0;
  localparam logic POL_FALL = 1'b1;

  typedef enum logic [3:0] {
    SEL_NONE,
    SEL_DATA_IN,
    SEL_DATA_OUT,
    SEL_DIR,
    SEL_IRQ_EN,
    SEL_IRQ_POL,
    SEL_IRQ_STAT,
    SEL_DEBOUNCE,
    SEL_DATA_SET,
    SEL_DATA_CLR
  } reg_sel_e;

  // Word address in (PADDR[7:2]); byte lane bits are don't-care.
  function automatic reg_sel_e reg_decode(input logic [5:0] word_addr);
    logic [7:0] off;
    off = {word_addr, 2'b00};
    reg_decode = SEL_NONE;
    case (off)
      OFF_DATA_IN:  reg_decode = SEL_DATA_IN;
      OFF_DATA_OUT: reg_decode = SEL_DATA_OUT;
      OFF_DIR:      reg_decode = SEL_DIR;
      OFF_IRQ_EN:   reg_decode = SEL_IRQ_EN;
      OFF_IRQ_POL:  reg_decode = SEL_IRQ_POL;
      OFF_IRQ_STAT: reg_decode = SEL_IRQ_STAT;
      OFF_DEBOUNCE: reg_decode = SEL_DEBOUNCE;
`ifdef GPIO_ATOMIC_EN
      OFF_DATA_SET: reg_decode = SEL_DATA_SET;
      OFF_DATA_CLR: reg_decode = SEL_DATA_CLR;
`endif
      default:      reg_decode = SEL_NONE;
    endcase
  endfunction

endpackage

// File: rtl/gpio_debounce.sv
// One GPIO input channel: 2-flop synchroniser, debounce counter, stable level
// and its 1-cycle delayed copy for edge detection.
module gpio_debounce #(
  parameter int DB_W = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            pin,
  input  logic [DB_W-1:0] db_val,
  output logic            stable,
  output logic            stable_d
);

  logic            s1, s2;
  logic [DB_W-1:0] cnt;

  // Equality compare (not >=) so a window shrunk mid-count finishes by wrapping.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1       <= 1'b0;
      s2       <= 1'b0;
      cnt      <= '0;
      stable   <= 1'b0;
      stable_d <= 1'b0;
    end else begin
      s1       <= pin;
      s2       <= s1;
      stable_d <= stable;
      if (s2 != stable) begin
        if (cnt == db_val) begin
          stable <= s2;
          cnt    <= '0;
        end else begin
          cnt <= cnt + DB_W'(1);
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/apb_gpio_bank.sv
// APB3 GPIO bank: NUM_IO pins with direction, debounced inputs and edge IRQ.
// Optional GPIO_ATOMIC_EN maps DATA_SET (0x1C) / DATA_CLR (0x20).
module apb_gpio_bank
  import gpio_pkg::*;
#(
  parameter int NUM_IO   = 8,
  parameter int DB_W     = 16,
  parameter int DB_RESET = 1000
) (
  input  logic              FAB_CLK,
  input  logic              M2F_RESET_N,
  input  logic              PSEL,
  input  logic              PENABLE,
  input  logic              PWRITE,
  input  logic [7:0]        PADDR,
  input  logic [31:0]       PWDATA,
  output logic [31:0]       PRDATA,
  output logic              PREADY,
  output logic              PSLVERR,
  input  logic [NUM_IO-1:0] GPIO_IN,
  output logic [NUM_IO-1:0] GPIO_OUT,
  output logic [NUM_IO-1:0] GPIO_OE,
  output logic              IRQ
);

  localparam logic [DB_W-1:0] DB_RST = DB_W'(DB_RESET);

  logic              access, bad, wr;
  reg_sel_e          sel;
  logic [NUM_IO-1:0] wdata, w1c;
  logic [NUM_IO-1:0] data_out, dir, irq_en, irq_pol, irq_stat;
  logic [DB_W-1:0]   db_reg;
  logic [NUM_IO-1:0] stable, stable_d, evt;
  logic              irq_q;
  logic              unused_bits;

  assign access = PSEL & PENABLE;
  assign sel    = reg_decode(PADDR[7:2]);
  assign bad    = (sel == SEL_NONE) || (PWRITE && sel == SEL_DATA_IN);
  assign wr     = access & PWRITE & ~bad;
  assign wdata  = PWDATA[NUM_IO-1:0];
  assign w1c    = (wr && sel == SEL_IRQ_STAT) ? wdata : '0;

  assign PREADY      = 1'b1;
  assign PSLVERR     = access & bad;
  assign GPIO_OUT    = data_out;
  assign GPIO_OE     = dir;
  assign IRQ         = irq_q;
  assign unused_bits = ^{PADDR[1:0], PWDATA};

  for (genvar i = 0; i < NUM_IO; i++) begin : g_ch
    gpio_debounce #(.DB_W(DB_W)) u_db (
      .clk     (FAB_CLK),
      .rst_n   (M2F_RESET_N),
      .pin     (GPIO_IN[i]),
      .db_val  (db_reg),
      .stable  (stable[i]),
      .stable_d(stable_d[i])
    );
    assign evt[i] = (irq_pol[i] == POL_FALL) ? (~stable[i] &  stable_d[i])
                                             : ( stable[i] & ~stable_d[i]);
  end

  always_ff @(posedge FAB_CLK) begin
    if (!M2F_RESET_N) begin
      data_out <= '0;
      dir      <= '0;
      irq_en   <= '0;
      irq_pol  <= '0;
      irq_stat <= '0;
      db_reg   <= DB_RST;
      irq_q    <= 1'b0;
    end else begin
      if (wr) begin
        case (sel)
          SEL_DATA_OUT: data_out <= wdata;
          SEL_DIR:      dir      <= wdata;
          SEL_IRQ_EN:   irq_en   <= wdata;
          SEL_IRQ_POL:  irq_pol  <= wdata;
          SEL_DEBOUNCE: db_reg   <= PWDATA[DB_W-1:0];
`ifdef GPIO_ATOMIC_EN
          SEL_DATA_SET: data_out <= data_out | wdata;
          SEL_DATA_CLR: data_out <= data_out & ~wdata;
`endif
          default: ;
        endcase
      end
      // A new event beats a same-cycle W1C on the same bit.
      irq_stat <= (irq_stat & ~w1c) | evt;
      irq_q    <= |(irq_stat & irq_en);
    end
  end

  always_comb begin
    PRDATA = '0;
    if (access) begin
      case (sel)
        SEL_DATA_IN:  PRDATA = 32'(stable);
        SEL_DATA_OUT: PRDATA = 32'(data_out);
        SEL_DIR:      PRDATA = 32'(dir);
        SEL_IRQ_EN:   PRDATA = 32'(irq_en);
        SEL_IRQ_POL:  PRDATA = 32'(irq_pol);
        SEL_IRQ_STAT: PRDATA = 32'(irq_stat);
        SEL_DEBOUNCE: PRDATA = 32'(db_reg);
        default:      PRDATA = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_gpio_bank.sv
// Directed bench for apb_gpio_bank (default parameters); follows GPIO_ATOMIC_EN.
module tb_apb_gpio_bank;

  logic        FAB_CLK = 1'b0;
  logic        M2F_RESET_N;
  logic        PSEL, PENABLE, PWRITE;
  logic [7:0]  PADDR;
  logic [31:0] PWDATA, PRDATA;
  logic        PREADY, PSLVERR;
  logic [7:0]  GPIO_IN, GPIO_OUT, GPIO_OE;
  logic        IRQ;

  int nchk = 0;
  int nerr = 0;

  apb_gpio_bank #(.NUM_IO(8), .DB_W(16), .DB_RESET(1000)) dut (
    .FAB_CLK    (FAB_CLK),
    .M2F_RESET_N(M2F_RESET_N),
    .PSEL       (PSEL),
    .PENABLE    (PENABLE),
    .PWRITE     (PWRITE),
    .PADDR      (PADDR),
    .PWDATA     (PWDATA),
    .PRDATA     (PRDATA),
    .PREADY     (PREADY),
    .PSLVERR    (PSLVERR),
    .GPIO_IN    (GPIO_IN),
    .GPIO_OUT   (GPIO_OUT),
    .GPIO_OE    (GPIO_OE),
    .IRQ        (IRQ)
  );

  always #5 FAB_CLK = ~FAB_CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Leaves the bus in the access phase, between clock edges.
  task automatic apb_begin(input logic [7:0] a, input logic w, input logic [31:0] d);
    @(negedge FAB_CLK);
    PSEL = 1'b1; PENABLE = 1'b0; PADDR = a; PWRITE = w; PWDATA = d;
    @(negedge FAB_CLK);
    PENABLE = 1'b1;
  endtask

  task automatic apb_end();
    @(posedge FAB_CLK);
    #1;
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
  endtask

  task automatic apb_write(input logic [7:0] a, input logic [31:0] d, output logic err);
    apb_begin(a, 1'b1, d);
    #1 err = PSLVERR;
    apb_end();
  endtask

  task automatic apb_read(input logic [7:0] a, output logic [31:0] d, output logic err);
    apb_begin(a, 1'b0, 32'h0);
    #1 d = PRDATA; err = PSLVERR;
    apb_end();
  endtask

  logic [31:0] rd;
  logic        er;

  initial begin
    M2F_RESET_N = 1'b0;
    PSEL = 0; PENABLE = 0; PWRITE = 0; PADDR = 0; PWDATA = 0; GPIO_IN = '0;
    repeat (2) @(posedge FAB_CLK);
    #1;
    chk("rst_gpio_out", 32'(GPIO_OUT), 0);
    chk("rst_gpio_oe",  32'(GPIO_OE), 0);
    chk("rst_irq",      32'(IRQ), 0);
    chk("rst_pready",   32'(PREADY), 1);
    chk("rst_pslverr",  32'(PSLVERR), 0);
    chk("rst_prdata",   PRDATA, 0);
    @(negedge FAB_CLK) M2F_RESET_N = 1'b1;
    apb_read(8'h18, rd, er); chk("rst_debounce", rd, 1000);
    apb_read(8'h00, rd, er); chk("rst_data_in", rd, 0);

    // Outputs and readback
    apb_write(8'h08, 32'h0F, er); chk("dir_err", 32'(er), 0);
    chk("gpio_oe", 32'(GPIO_OE), 32'h0F);
    apb_write(8'h04, 32'hA5, er);
    chk("gpio_out", 32'(GPIO_OUT), 32'hA5);
    apb_read(8'h08, rd, er); chk("rd_dir", rd, 32'h0F);
    apb_read(8'h04, rd, er); chk("rd_data_out", rd, 32'hA5);
    apb_write(8'h0C, 32'hFFFF_FF00, er);
    apb_read(8'h0C, rd, er); chk("irq_en_upper_ignored", rd, 0);

    // Error paths
    apb_write(8'h24, 32'hFF, er); chk("unmapped_wr_err", 32'(er), 1);
    apb_read(8'h24, rd, er);
    chk("unmapped_rd_err", 32'(er), 1); chk("unmapped_rd_data", rd, 0);
    apb_write(8'h00, 32'hFF, er); chk("data_in_wr_err", 32'(er), 1);
    apb_read(8'h08, rd, er); chk("dir_unchanged", rd, 32'h0F);
    apb_read(8'h05, rd, er); chk("byte_lane_ignored", rd, 32'hA5);

    // Debounce = 4: pin 0 rise seen on edge 7
    apb_write(8'h18, 32'hFFFF_0004, er);
    apb_read(8'h18, rd, er); chk("debounce_masked", rd, 4);
    apb_begin(8'h00, 1'b0, 0);
    GPIO_IN[0] = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(posedge FAB_CLK); #1;
      chk($sformatf("db_rise_edge%0d", k), 32'(PRDATA[0]), (k >= 7) ? 1 : 0);
    end
    apb_end();

    // 3-cycle glitch on pin 1 is filtered
    apb_begin(8'h00, 1'b0, 0);
    GPIO_IN[1] = 1'b1;
    repeat (3) @(posedge FAB_CLK);
    @(negedge FAB_CLK) GPIO_IN[1] = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      @(posedge FAB_CLK); #1;
      if (k == 4 || k == 12) chk($sformatf("glitch_edge%0d", k), PRDATA, 32'h01);
    end
    apb_end();

    // Rising IRQ on pin 0
    apb_write(8'h14, 32'hFF, er);
    apb_read(8'h14, rd, er); chk("stat_cleared", rd, 0);
    @(negedge FAB_CLK) GPIO_IN[0] = 1'b0;
    repeat (10) @(posedge FAB_CLK);
    apb_read(8'h14, rd, er); chk("fall_ignored_rise_pol", rd, 0);
    apb_write(8'h0C, 32'h01, er);
    apb_begin(8'h14, 1'b0, 0);
    GPIO_IN[0] = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      @(posedge FAB_CLK); #1;
      chk($sformatf("stat_edge%0d", k), 32'(PRDATA[0]), (k >= 8) ? 1 : 0);
      chk($sformatf("irq_edge%0d", k), 32'(IRQ), (k >= 9) ? 1 : 0);
    end
    apb_end();

    // W1C on the same edge as a new event: set wins
    @(negedge FAB_CLK) GPIO_IN[0] = 1'b0;
    repeat (10) @(posedge FAB_CLK);
    @(negedge FAB_CLK) GPIO_IN[0] = 1'b1;
    repeat (6) @(posedge FAB_CLK);
    apb_write(8'h14, 32'h01, er);
    apb_read(8'h14, rd, er); chk("w1c_vs_event", rd, 32'h01);
    chk("irq_held", 32'(IRQ), 1);

    // Plain W1C drops IRQ one cycle later
    apb_write(8'h14, 32'h01, er);
    chk("irq_after_w1c_edge", 32'(IRQ), 1);
    @(posedge FAB_CLK); #1;
    chk("irq_dropped", 32'(IRQ), 0);
    apb_read(8'h14, rd, er); chk("stat_after_w1c", rd, 0);

    // Falling polarity on pin 2
    apb_write(8'h10, 32'h04, er);
    @(negedge FAB_CLK) GPIO_IN[2] = 1'b1;
    repeat (10) @(posedge FAB_CLK);
    apb_read(8'h14, rd, er); chk("pol_fall_rise_ignored", rd, 0);
    @(negedge FAB_CLK) GPIO_IN[2] = 1'b0;
    repeat (10) @(posedge FAB_CLK);
    apb_read(8'h14, rd, er); chk("pol_fall_stat", rd, 32'h04);
    chk("irq_masked", 32'(IRQ), 0);
    apb_write(8'h0C, 32'h05, er);
    chk("irq_en_latency0", 32'(IRQ), 0);
    @(posedge FAB_CLK); #1;
    chk("irq_en_latency1", 32'(IRQ), 1);

`ifdef GPIO_ATOMIC_EN
    apb_write(8'h04, 32'h0F, er);
    apb_write(8'h1C, 32'h30, er); chk("set_err", 32'(er), 0);
    chk("set_out", 32'(GPIO_OUT), 32'h3F);
    apb_write(8'h20, 32'h05, er);
    chk("clr_out", 32'(GPIO_OUT), 32'h3A);
    apb_read(8'h1C, rd, er); chk("set_reads0", rd, 0); chk("set_rd_err", 32'(er), 0);
    apb_read(8'h04, rd, er); chk("atomic_readback", rd, 32'h3A);
`else
    apb_write(8'h1C, 32'h30, er); chk("set_unmapped_err", 32'(er), 1);
    apb_write(8'h20, 32'hFF, er); chk("clr_unmapped_err", 32'(er), 1);
    chk("gpio_out_unchanged", 32'(GPIO_OUT), 32'hA5);
`endif

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
